secure_config_frame_loader: RTL

//  On-die receive end of the encrypted test-configuration path. Accepts a framed
//  {nonce, ciphertext, tag} packet over a 32-bit valid/ready word stream and drives
//  an external Ascon-128 decryptor through a start/done handshake. It commits the

---
 rtl/secure_config_frame_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/secure_config_frame_loader.sv
// rtl/secure_config_frame_loader.sv - Receives an encrypted config frame, drives the decryptor, commits on tag success.
module secure_config_frame_loader #(
    parameter int MAX_FAILS = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         s_ready,
    output logic         dec_start,
    output logic [127:0] dec_nonce,
    output logic [127:0] dec_cipher,
    output logic [127:0] dec_tag,
    input  logic [127:0] dec_plain,
    input  logic         dec_tag_valid,
    input  logic         dec_done,
    output logic [127:0] cfg_out,
    output logic         cfg_valid,
    output logic         cfg_update,
    output logic         auth_fail,
    output logic         frame_err,
    output logic [1:0]   fail_count,
    output logic         locked
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RECV, WAIT, LOCKED} state_t;

    state_t        state;
    logic [3:0]    word_cnt;
    logic [TW-1:0] timer;
    logic [6:0]    bit_lo;
    logic [1:0]    fail_inc;

    // Word n lands MSW first within its 128-bit field: low bit = 32*(3 - n%4).
    assign bit_lo   = {~word_cnt[1:0], 5'b0};
    assign fail_inc = (fail_count == 2'(MAX_FAILS)) ? fail_count : fail_count + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_cnt   <= 4'd0;
            timer      <= '0;
            s_ready    <= 1'b0;
            dec_start  <= 1'b0;
            dec_nonce  <= '0;
            dec_cipher <= '0;
            dec_tag    <= '0;
            cfg_out    <= '0;
            cfg_valid  <= 1'b0;
            cfg_update <= 1'b0;
            auth_fail  <= 1'b0;
            frame_err  <= 1'b0;
            fail_count <= 2'd0;
            locked     <= 1'b0;
        end else begin
            dec_start  <= 1'b0;
            cfg_update <= 1'b0;
            auth_fail  <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE, RECV: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        case (word_cnt[3:2])
                            2'd0:    dec_nonce[bit_lo +: 32]  <= s_data;
                            2'd1:    dec_cipher[bit_lo +: 32] <= s_data;
                            default: dec_tag[bit_lo +: 32]    <= s_data;
                        endcase
                        if (s_last != (word_cnt == 4'd11)) begin
                            frame_err <= 1'b1;
                            word_cnt  <= 4'd0;
                            state     <= IDLE;
                        end else if (s_last) begin
                            dec_start <= 1'b1;
                            word_cnt  <= 4'd0;
                            timer     <= '0;
                            s_ready   <= 1'b0;
                            state     <= WAIT;
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                            state    <= RECV;
                        end
                    end
                end
                WAIT: begin
                    if (dec_done && dec_tag_valid) begin
                        cfg_out    <= dec_plain;
                        cfg_valid  <= 1'b1;
                        cfg_update <= 1'b1;
                        fail_count <= 2'd0;
                        s_ready    <= 1'b1;
                        state      <= IDLE;
                    end else if (dec_done || timer == TW'(TIMEOUT)) begin
                        auth_fail  <= 1'b1;
                        fail_count <= fail_inc;
                        if (fail_inc == 2'(MAX_FAILS)) begin
                            locked <= 1'b1;
                            state  <= LOCKED;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    locked  <= 1'b1;
                end
            endcase
        end
    end

endmodule
